// File: rtl/butterfly_r2_pipe.sv
// Radix-2 DIT butterfly: out0 = a + W*b, out1 = a - W*b.
// Signed fixed point with valid/ready flow control, conj(W) for the inverse
// transform, optional halving, round-half-up and saturation.
// Pipeline: input register, MULT_STAGES multiply registers, output register.
module butterfly_r2_pipe #(
  parameter int WIDTH       = 16,
  parameter int FRAC_BITS   = 14,
  parameter int MULT_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a_real,
  input  logic signed [WIDTH-1:0] a_imag,
  input  logic signed [WIDTH-1:0] b_real,
  input  logic signed [WIDTH-1:0] b_imag,
  input  logic signed [WIDTH-1:0] w_real,
  input  logic signed [WIDTH-1:0] w_imag,
  input  logic                    inverse,
  input  logic                    scale,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out0_real,
  output logic signed [WIDTH-1:0] out0_imag,
  output logic signed [WIDTH-1:0] out1_real,
  output logic signed [WIDTH-1:0] out1_imag,
  output logic                    ovf
);

  localparam int PW = 2 * WIDTH + 2;
  localparam int L  = MULT_STAGES - 1;

  localparam logic signed [WIDTH:0]  S_MAX = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0]  S_MIN = {2'b11, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0]   T_MAX = PW'(S_MAX);
  localparam logic signed [PW-1:0]   T_MIN = PW'(S_MIN);
  localparam logic signed [PW-1:0]   RND   = PW'(1) << (FRAC_BITS - 1);

  // Returns {saturated, value} for a full-precision rounded product.
  function automatic logic [WIDTH:0] sat_t(input logic signed [PW-1:0] x);
    if (x > T_MAX)      return {1'b1, T_MAX[WIDTH-1:0]};
    else if (x < T_MIN) return {1'b1, T_MIN[WIDTH-1:0]};
    else                return {1'b0, x[WIDTH-1:0]};
  endfunction

  // Returns {saturated, value}; halving uses floor(s/2) + lsb == (s+1)>>>1,
  // which cannot leave the WIDTH range because |a|,|t| <= 2^(WIDTH-1).
  function automatic logic [WIDTH:0] finish(input logic signed [WIDTH:0] s,
                                            input logic sc);
    logic [WIDTH-1:0] half;
    half = s[WIDTH:1] + WIDTH'(s[0]);
    if (sc)             return {1'b0, half};
    else if (s > S_MAX) return {1'b1, S_MAX[WIDTH-1:0]};
    else if (s < S_MIN) return {1'b1, S_MIN[WIDTH-1:0]};
    else                return {1'b0, s[WIDTH-1:0]};
  endfunction

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !reset;

  // Conjugation done one bit wider so negating the most negative value is exact
  logic signed [WIDTH:0] wi_ext, wi_eff;
  assign wi_ext = (WIDTH+1)'(w_imag);
  assign wi_eff = inverse ? -wi_ext : wi_ext;

  // Input stage
  logic signed [WIDTH-1:0] a0_re, a0_im, b0_re, b0_im, w0_re;
  logic signed [WIDTH:0]   w0_im;
  logic                    sc0, v0;

  // Multiply stages
  logic signed [PW-1:0]    pr_q [MULT_STAGES];
  logic signed [PW-1:0]    pi_q [MULT_STAGES];
  logic signed [WIDTH-1:0] am_re [MULT_STAGES];
  logic signed [WIDTH-1:0] am_im [MULT_STAGES];
  logic [MULT_STAGES-1:0]  sc_q, v_q;

  logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x, pr_c, pi_c;
  assign br_x = PW'(b0_re);
  assign bi_x = PW'(b0_im);
  assign wr_x = PW'(w0_re);
  assign wi_x = PW'(w0_im);
  assign pr_c = br_x * wr_x - bi_x * wi_x;
  assign pi_c = br_x * wi_x + bi_x * wr_x;

  // Round, saturate, add/subtract and scale from the last multiply stage
  logic signed [PW-1:0]    tr_full, ti_full;
  logic [WIDTH:0]          tr_s, ti_s, f0r, f0i, f1r, f1i;
  logic signed [WIDTH-1:0] t_re, t_im;
  logic signed [WIDTH:0]   s0_re, s0_im, s1_re, s1_im;

  always_comb begin
    tr_full = (pr_q[L] + RND) >>> FRAC_BITS;
    ti_full = (pi_q[L] + RND) >>> FRAC_BITS;
    tr_s    = sat_t(tr_full);
    ti_s    = sat_t(ti_full);
    t_re    = tr_s[WIDTH-1:0];
    t_im    = ti_s[WIDTH-1:0];
    s0_re   = (WIDTH+1)'(am_re[L]) + (WIDTH+1)'(t_re);
    s0_im   = (WIDTH+1)'(am_im[L]) + (WIDTH+1)'(t_im);
    s1_re   = (WIDTH+1)'(am_re[L]) - (WIDTH+1)'(t_re);
    s1_im   = (WIDTH+1)'(am_im[L]) - (WIDTH+1)'(t_im);
    f0r     = finish(s0_re, sc_q[L]);
    f0i     = finish(s0_im, sc_q[L]);
    f1r     = finish(s1_re, sc_q[L]);
    f1i     = finish(s1_im, sc_q[L]);
  end

  // Valid bits and output register: cleared by reset, held while stalled
  always_ff @(posedge clock) begin
    if (reset) begin
      v0        <= 1'b0;
      v_q       <= '0;
      out_valid <= 1'b0;
      out0_real <= '0;
      out0_imag <= '0;
      out1_real <= '0;
      out1_imag <= '0;
      ovf       <= 1'b0;
    end else if (advance) begin
      v0     <= in_valid;
      v_q[0] <= v0;
      for (int unsigned i = 1; i < MULT_STAGES; i++) v_q[i] <= v_q[i-1];
      out_valid <= v_q[L];
      out0_real <= f0r[WIDTH-1:0];
      out0_imag <= f0i[WIDTH-1:0];
      out1_real <= f1r[WIDTH-1:0];
      out1_imag <= f1i[WIDTH-1:0];
      ovf       <= tr_s[WIDTH] | ti_s[WIDTH] | f0r[WIDTH] | f0i[WIDTH] |
                   f1r[WIDTH] | f1i[WIDTH];
    end
  end

  // Datapath registers; contents behind a cleared valid bit are don't-care
  always_ff @(posedge clock) begin
    if (advance) begin
      a0_re <= a_real;
      a0_im <= a_imag;
      b0_re <= b_real;
      b0_im <= b_imag;
      w0_re <= w_real;
      w0_im <= wi_eff;
      sc0   <= scale;
      pr_q[0]  <= pr_c;
      pi_q[0]  <= pi_c;
      am_re[0] <= a0_re;
      am_im[0] <= a0_im;
      sc_q[0]  <= sc0;
      for (int unsigned i = 1; i < MULT_STAGES; i++) begin
        pr_q[i]  <= pr_q[i-1];
        pi_q[i]  <= pi_q[i-1];
        am_re[i] <= am_re[i-1];
        am_im[i] <= am_im[i-1];
        sc_q[i]  <= sc_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Self-checking bench for butterfly_r2_pipe (WIDTH=16, FRAC_BITS=14,
// MULT_STAGES=2). A negedge monitor pushes model results on every accepted
// sample and pops/compares them on every consumed result.
module tb_butterfly_r2_pipe;

  localparam int W  = 16;
  localparam int FB = 14;

  logic clock = 1'b0;
  logic reset, in_valid, in_ready, inverse, scale, out_valid, out_ready, ovf;
  logic signed [W-1:0] a_real, a_imag, b_real, b_imag, w_real, w_imag;
  logic signed [W-1:0] out0_real, out0_imag, out1_real, out1_imag;

  typedef struct packed {
    logic [W-1:0] o0r, o0i, o1r, o1i;
    logic         ov;
  } res_t;

  res_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;

  always #5 clock = ~clock;

  butterfly_r2_pipe #(.WIDTH(W), .FRAC_BITS(FB), .MULT_STAGES(2)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .w_real(w_real), .w_imag(w_imag), .inverse(inverse), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .out0_real(out0_real), .out0_imag(out0_imag),
    .out1_real(out1_real), .out1_imag(out1_imag), .ovf(ovf)
  );

  // Integer reference of the butterfly arithmetic
  function automatic res_t model(input longint ar, ai, br, bi, wr, wi,
                                 input bit inv, sc);
    longint wie, t[2], s[4], o[4];
    longint maxv = (64'sd1 <<< (W-1)) - 1;
    longint minv = -(64'sd1 <<< (W-1));
    longint half = 64'sd1 <<< (FB-1);
    bit ov = 1'b0;
    wie  = inv ? -wi : wi;
    t[0] = (br * wr - bi * wie + half) >>> FB;
    t[1] = (br * wie + bi * wr + half) >>> FB;
    for (int k = 0; k < 2; k++) begin
      if (t[k] > maxv) begin t[k] = maxv; ov = 1'b1; end
      if (t[k] < minv) begin t[k] = minv; ov = 1'b1; end
    end
    s[0] = ar + t[0]; s[1] = ai + t[1]; s[2] = ar - t[0]; s[3] = ai - t[1];
    for (int k = 0; k < 4; k++) begin
      if (sc) o[k] = (s[k] + 1) >>> 1;
      else if (s[k] > maxv) begin o[k] = maxv; ov = 1'b1; end
      else if (s[k] < minv) begin o[k] = minv; ov = 1'b1; end
      else o[k] = s[k];
    end
    return {16'(o[0]), 16'(o[1]), 16'(o[2]), 16'(o[3]), ov};
  endfunction

  // Scoreboard monitor, sampling mid-cycle
  always @(negedge clock) begin
    res_t e, act;
    if (reset) sbq.delete();
    else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_cmp++;
        act = {out0_real, out0_imag, out1_real, out1_imag, ovf};
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard: unexpected result got %h expected none", act);
        end else begin
          e = sbq.pop_front();
          n_pop++;
          if (act !== e) begin
            n_bad++;
            $display("FAIL scoreboard: got (%0d,%0d)(%0d,%0d) ovf=%b expected (%0d,%0d)(%0d,%0d) ovf=%b",
                     out0_real, out0_imag, out1_real, out1_imag, ovf,
                     $signed(e.o0r), $signed(e.o0i), $signed(e.o1r), $signed(e.o1i), e.ov);
          end
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1)
        sbq.push_back(model(a_real, a_imag, b_real, b_imag, w_real, w_imag, inverse, scale));
    end
  end

  task automatic set_in(input int ar, ai, br, bi, wr, wi, input bit inv, sc);
    a_real = 16'(ar); a_imag = 16'(ai);
    b_real = 16'(br); b_imag = 16'(bi);
    w_real = 16'(wr); w_imag = 16'(wi);
    inverse = inv; scale = sc;
  endtask

  // Present one sample until accepted; returns at posedge+1 after the accept edge
  task automatic send(input int ar, ai, br, bi, wr, wi, input bit inv, sc);
    bit acc = 1'b0;
    int g = 0;
    set_in(ar, ai, br, bi, wr, wi, inv, sc);
    in_valid = 1'b1;
    while (!acc && g < 50) begin
      @(negedge clock); acc = in_ready;
      @(posedge clock); #1; g++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
    end
  endtask

  // Count edges, accept edge included, until out_valid shows
  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 30) begin
      @(posedge clock); #1; lat++;
    end
    if (out_valid !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL out_timeout: out_valid=%b expected 1", out_valid);
    end
  endtask

  task automatic drain();
    int g = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while ((sbq.size() != 0 || out_valid === 1'b1) && g < 50) begin
      @(posedge clock); #1; g++;
    end
    if (g >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: pending=%0d expected 0", sbq.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({out_valid, in_ready, ovf, out0_real, out0_imag, out1_real, out1_imag} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b ready=%b ovf=%b out=(%0d,%0d)(%0d,%0d) expected all 0",
               out_valid, in_ready, ovf, out0_real, out0_imag, out1_real, out1_imag);
    end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_reset: got %b expected 1", in_ready);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    send(16384, 0, 8192, 0, 16384, 0, 0, 0);
    wait_out(lat);
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL latency: got %0d expected 4", lat); end
    n_cmp++;
    if ({out0_real, out0_imag, out1_real, out1_imag, ovf} !== {16'sd24576, 16'sd0, 16'sd8192, 16'sd0, 1'b0}) begin
      n_bad++;
      $display("FAIL basic: got (%0d,%0d)(%0d,%0d) ovf=%b expected (24576,0)(8192,0) ovf=0",
               out0_real, out0_imag, out1_real, out1_imag, ovf);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_inverse();
    int lat;
    logic signed [W-1:0] e0i, e1i;
    for (int inv = 0; inv < 2; inv++) begin
      send(0, 0, 8192, 0, 0, -16384, inv[0], 0);
      wait_out(lat);
      e0i = inv ? 16'sd8192 : -16'sd8192;
      e1i = -e0i;
      n_cmp++;
      if ({out0_real, out0_imag, out1_real, out1_imag} !== {16'sd0, e0i, 16'sd0, e1i}) begin
        n_bad++;
        $display("FAIL inverse%0d: got (%0d,%0d)(%0d,%0d) expected (0,%0d)(0,%0d)",
                 inv, out0_real, out0_imag, out1_real, out1_imag, e0i, e1i);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [4*W:0] exp_v [2];
    exp_v[0] = {16'sd32767, 16'sd0, 16'sd16383, 16'sd0, 1'b1};
    exp_v[1] = {16'sd24576, 16'sd0, 16'sd8192,  16'sd0, 1'b0};
    for (int sc = 0; sc < 2; sc++) begin
      send(32767, 0, 16384, 0, 16384, 0, 0, sc[0]);
      wait_out(lat);
      n_cmp++;
      if ({out0_real, out0_imag, out1_real, out1_imag, ovf} !== exp_v[sc]) begin
        n_bad++;
        $display("FAIL saturate_scale%0d: got %h expected %h", sc,
                 {out0_real, out0_imag, out1_real, out1_imag, ovf}, exp_v[sc]);
      end
      @(posedge clock); #1;
    end
    // Extreme corners, including conj of the most negative twiddle
    send(-32768, -32768, -32768, 0, -32768, -32768, 1, 0);
    send(-32768, 32767, -32768, -32768, -32768, -32768, 0, 1);
    send(32767, -32768, 32767, 32767, 16384, -32768, 1, 0);
    drain();
  endtask

  task automatic test_rounding();
    int lat;
    int bv [2] = '{1, -1};
    int ev [2] = '{1, 0};
    for (int k = 0; k < 2; k++) begin
      send(0, 0, bv[k], 0, 8192, 0, 0, 0);
      wait_out(lat);
      n_cmp++;
      if (out0_real !== 16'(ev[k])) begin
        n_bad++;
        $display("FAIL rounding_b%0d: got %0d expected %0d", bv[k], out0_real, ev[k]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    int k = 0, cyc = 0, stalls = 0, pop0;
    bit acc, have_snap = 1'b0, bad_hold = 1'b0;
    logic [4*W:0] snap;
    pop0 = n_pop;
    while (k < 10 && cyc < 200) begin
      set_in(k * 1000, -k * 500, k * 300 + 7, 100 - k, 16384 - k * 1000, k * 800, k[0], k == 3);
      in_valid = 1'b1;
      out_ready = !(cyc >= 5 && cyc < 10);
      @(negedge clock);
      if (!out_ready && out_valid === 1'b1) begin
        stalls++;
        if (in_ready !== 1'b0) bad_hold = 1'b1;
        if (!have_snap) begin
          snap = {out0_real, out0_imag, out1_real, out1_imag, ovf};
          have_snap = 1'b1;
        end else if ({out0_real, out0_imag, out1_real, out1_imag, ovf} !== snap) bad_hold = 1'b1;
      end
      acc = in_ready;
      @(posedge clock); #1;
      if (acc) k++;
      cyc++;
    end
    drain();
    n_cmp++;
    if (stalls !== 5) begin n_bad++; $display("FAIL stall_cycles: got %0d expected 5", stalls); end
    n_cmp++;
    if (bad_hold) begin n_bad++; $display("FAIL stall_hold: got changed outputs/in_ready expected stable, in_ready=0"); end
    n_cmp++;
    if (n_pop - pop0 !== 10) begin n_bad++; $display("FAIL delivered: got %0d expected 10", n_pop - pop0); end
  endtask

  task automatic test_reset_midstream();
    int lat, seen = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(1000 + k, 2000, 4000, -3000, 16384, 8192, 0, 0);
      in_valid = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ready_in_reset: got %b expected 0", in_ready); end
    @(posedge clock); #1 reset = 1'b0;
    n_cmp++;
    if ({out_valid, ovf, out0_real, out0_imag, out1_real, out1_imag} !== '0) begin
      n_bad++;
      $display("FAIL midstream_reset_out: valid=%b out=(%0d,%0d)(%0d,%0d) expected all 0",
               out_valid, out0_real, out0_imag, out1_real, out1_imag);
    end
    repeat (8) begin
      @(negedge clock); if (out_valid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL flushed_samples: got %0d valid cycles expected 0", seen); end
    @(posedge clock); #1;
    send(-5000, 7000, 12000, -9000, 11585, -11585, 1, 0);
    wait_out(lat);
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL latency_after_reset: got %0d expected 4", lat); end
    @(posedge clock); #1;
  endtask

  function automatic int rnd16();
    int pick [4] = '{-32768, 32767, 16384, -16384};
    if ($urandom_range(0, 3) == 0) return pick[$urandom_range(0, 3)];
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic test_random();
    for (int c = 0; c < 150; c++) begin
      set_in(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inverse();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    drain();
    n_cmp++;
    if (sbq.size() !== 0) begin n_bad++; $display("FAIL leftover: got %0d pending expected 0", sbq.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
